// File: rtl/axi_pkg.sv
// Shared AXI encodings, W-channel FSM states and helpers for the burst write slave.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One past the last byte of a 4KB page, in 17 bits so an end address can exceed it.
    localparam logic [16:0] BOUNDARY_4KB = 17'd4096;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_DATA = 1'b1
    } w_state_t;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input logic [7:0] len);
        logic ok;
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; head data is visible combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage write; contents need no reset because empty gates every consumer.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/axi_wr_burst_slave.sv
// AXI write-burst slave: queues AW requests, walks each burst's beats onto a
// registered memory write port, and returns in-order B responses.
module axi_wr_burst_slave
    import axi_pkg::*;
#(
    parameter int IDW         = 4,
    parameter int AW          = 32,
    parameter int DW          = 64,
    parameter int OUTSTANDING = 4
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic [IDW-1:0]                axi_awid,
    input  logic [AW-1:0]                 axi_awaddr,
    input  logic [7:0]                    axi_awlen,
    input  logic [2:0]                    axi_awsize,
    input  logic [1:0]                    axi_awburst,
    input  logic                          axi_awvalid,
    output logic                          axi_awready,
    input  logic [DW-1:0]                 axi_wdata,
    input  logic [DW/8-1:0]               axi_wstrb,
    input  logic                          axi_wlast,
    input  logic                          axi_wvalid,
    output logic                          axi_wready,
    output logic [IDW-1:0]                axi_bid,
    output logic [1:0]                    axi_bresp,
    output logic                          axi_bvalid,
    input  logic                          axi_bready,
    output logic                          mem_we,
    output logic [AW-1:0]                 mem_addr,
    output logic [DW-1:0]                 mem_wdata,
    output logic [DW/8-1:0]               mem_wstrb,
    output logic                          err_wlast,
    output logic [$clog2(OUTSTANDING):0]  outstanding
);

    localparam int            AQW      = IDW + AW + 8 + 3 + 2 + 1;
    localparam int            BQW      = IDW + 2;
    localparam logic [2:0]    MAX_SIZE = 3'($clog2(DW/8));
    localparam logic [AW-1:0] ONE_A    = AW'(1);

    // AW queue signals
    logic [AQW-1:0]  aw_head_s;
    logic            aw_full_s, aw_empty_s, aw_hs_s, aw_pop_s, aw_illegal_s;
    logic [15:0]     aw_bytes_s;
    logic [16:0]     aw_end_s;
    logic [IDW-1:0]  hd_id_s;
    logic [AW-1:0]   hd_addr_s;
    logic [7:0]      hd_len_s;
    logic [2:0]      hd_size_s;
    logic [1:0]      hd_burst_s;
    logic            hd_illegal_s;

    // B queue signals
    logic [BQW-1:0]  b_head_s;
    logic            b_full_s, b_empty_s, b_push_s, b_pop_s;
    logic [IDW-1:0]  b_head_id_s;
    logic [1:0]      b_head_resp_s;

    // Working burst registers
    w_state_t        state_r;
    logic [IDW-1:0]  id_r;
    logic [AW-1:0]   addr_r;
    logic [7:0]      len_r, beat_r;
    logic [2:0]      size_r;
    logic [1:0]      burst_r, resp_r;
    logic            illegal_r, ready_en_r;
    logic            w_hs_s, last_beat_s, mismatch_s;
    logic [AW-1:0]   incr_s, wrap_mask_s, next_addr_s;

    // Output registers
    logic            mem_we_r, err_wlast_r;
    logic [AW-1:0]   mem_addr_r;
    logic [DW-1:0]   mem_wdata_r;
    logic [DW/8-1:0] mem_wstrb_r;

    assign axi_awready = ready_en_r && !aw_full_s;
    assign aw_hs_s     = axi_awvalid && axi_awready;
    assign aw_pop_s    = (state_r == W_IDLE) && !aw_empty_s;
    assign {hd_id_s, hd_addr_s, hd_len_s, hd_size_s, hd_burst_s, hd_illegal_s} = aw_head_s;

    assign axi_wready  = (state_r == W_DATA) && !b_full_s;
    assign w_hs_s      = axi_wvalid && axi_wready;
    assign last_beat_s = (beat_r == len_r);
    assign mismatch_s  = w_hs_s && (axi_wlast != last_beat_s);
    assign b_push_s    = w_hs_s && last_beat_s;

    assign {b_head_id_s, b_head_resp_s} = b_head_s;
    assign axi_bvalid = !b_empty_s;
    assign axi_bid    = axi_bvalid ? b_head_id_s : {IDW{1'b0}};
    assign axi_bresp  = axi_bvalid ? b_head_resp_s : RESP_OKAY;
    assign b_pop_s    = axi_bvalid && axi_bready;

    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign mem_wstrb   = mem_wstrb_r;
    assign err_wlast   = err_wlast_r;

    // Classify an incoming AW so illegal bursts are known before any beat arrives.
    always_comb begin
        aw_bytes_s   = ({8'd0, axi_awlen} + 16'd1) << axi_awsize;
        aw_end_s     = {5'd0, axi_awaddr[11:0]} + {1'b0, aw_bytes_s};
        aw_illegal_s = 1'b0;
        if (axi_awburst == BURST_RSVD) begin
            aw_illegal_s = 1'b1;
        end else if ((axi_awburst == BURST_WRAP) && !wrap_len_legal(axi_awlen)) begin
            aw_illegal_s = 1'b1;
        end else if (axi_awsize > MAX_SIZE) begin
            aw_illegal_s = 1'b1;
        end else if ((axi_awburst == BURST_INCR) && (aw_end_s > BOUNDARY_4KB)) begin
            aw_illegal_s = 1'b1;
        end else begin
            aw_illegal_s = 1'b0;
        end
    end

    // Next beat address; WRAP keeps the upper bits and wraps the low bits inside the burst window.
    always_comb begin
        incr_s      = ONE_A << size_r;
        wrap_mask_s = ((AW'(len_r) + ONE_A) << size_r) - ONE_A;
        case (burst_r)
            BURST_FIXED: next_addr_s = addr_r;
            BURST_INCR:  next_addr_s = addr_r + incr_s;
            BURST_WRAP:  next_addr_s = (addr_r & ~wrap_mask_s) | ((addr_r + incr_s) & wrap_mask_s);
            default:     next_addr_s = addr_r;
        endcase
    end

    // W-channel FSM: load a burst from the AW queue, then count its beats to completion.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_r    <= W_IDLE;
            ready_en_r <= 1'b0;
            id_r       <= {IDW{1'b0}};
            addr_r     <= {AW{1'b0}};
            len_r      <= 8'd0;
            beat_r     <= 8'd0;
            size_r     <= 3'd0;
            burst_r    <= 2'b00;
            illegal_r  <= 1'b0;
            resp_r     <= RESP_OKAY;
        end else begin
            ready_en_r <= 1'b1;
            case (state_r)
                W_IDLE: begin
                    if (aw_pop_s) begin
                        id_r      <= hd_id_s;
                        addr_r    <= hd_addr_s;
                        len_r     <= hd_len_s;
                        size_r    <= hd_size_s;
                        burst_r   <= hd_burst_s;
                        illegal_r <= hd_illegal_s;
                        beat_r    <= 8'd0;
                        resp_r    <= hd_illegal_s ? RESP_SLVERR : RESP_OKAY;
                        state_r   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        addr_r <= next_addr_s;
                        beat_r <= beat_r + 8'd1;
                        if (mismatch_s) begin
                            resp_r <= RESP_SLVERR;
                        end
                        if (last_beat_s) begin
                            state_r <= W_IDLE;
                        end
                    end
                end
                default: state_r <= W_IDLE;
            endcase
        end
    end

    // Registered backend write port and WLAST-mismatch pulse.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            mem_wstrb_r <= {(DW/8){1'b0}};
            err_wlast_r <= 1'b0;
        end else begin
            err_wlast_r <= mismatch_s;
            mem_we_r    <= w_hs_s && !illegal_r;
            if (w_hs_s) begin
                mem_addr_r  <= addr_r;
                mem_wdata_r <= axi_wdata;
                mem_wstrb_r <= axi_wstrb;
            end
        end
    end

    sync_fifo #(.WIDTH(AQW), .DEPTH(OUTSTANDING)) u_aw_fifo (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .push      (aw_hs_s),
        .push_data ({axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, aw_illegal_s}),
        .pop       (aw_pop_s),
        .pop_data  (aw_head_s),
        .full      (aw_full_s),
        .empty     (aw_empty_s),
        .count     (outstanding)
    );

    sync_fifo #(.WIDTH(BQW), .DEPTH(OUTSTANDING)) u_b_fifo (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .push      (b_push_s),
        .push_data ({id_r, (mismatch_s ? RESP_SLVERR : resp_r)}),
        .pop       (b_pop_s),
        .pop_data  (b_head_s),
        .full      (b_full_s),
        .empty     (b_empty_s),
        .count     ()
    );

endmodule

// File: tb/tb_axi_wr_burst_slave.sv
// Directed self-checking bench for axi_wr_burst_slave (default parameters).
module tb_axi_wr_burst_slave;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic [3:0]  axi_awid = 4'd0;
    logic [31:0] axi_awaddr = 32'd0;
    logic [7:0]  axi_awlen = 8'd0;
    logic [2:0]  axi_awsize = 3'd0;
    logic [1:0]  axi_awburst = 2'd0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [63:0] axi_wdata = 64'd0;
    logic [7:0]  axi_wstrb = 8'd0;
    logic        axi_wlast = 1'b0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [3:0]  axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        err_wlast;
    logic [2:0]  outstanding;

    int checks = 0;
    int errors = 0;

    always #5 axi_aclk = ~axi_aclk;

    axi_wr_burst_slave #(.IDW(4), .AW(32), .DW(64), .OUTSTANDING(4)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .err_wlast(err_wlast), .outstanding(outstanding)
    );

    // Present one AW at a negedge, hold until accepted; returns on the negedge after the handshake.
    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t;
        t = 0;
        axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
        axi_awvalid = 1'b1;
        while (axi_awready !== 1'b1 && t < 200) begin
            @(negedge axi_aclk);
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL aw_timeout id=%0d awready=%b required 1", id, axi_awready);
        end
        @(negedge axi_aclk);
        axi_awvalid = 1'b0;
    endtask

    // Present one W beat, hold until accepted; returns on the negedge after the handshake.
    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int t;
        t = 0;
        axi_wdata = data; axi_wstrb = strb; axi_wlast = last; axi_wvalid = 1'b1;
        while (axi_wready !== 1'b1 && t < 200) begin
            @(negedge axi_aclk);
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL w_timeout wready=%b required 1", axi_wready);
        end
        @(negedge axi_aclk);
        axi_wvalid = 1'b0;
    endtask

    task automatic pop_b();
        axi_bready = 1'b1;
        @(negedge axi_aclk);
        axi_bready = 1'b0;
    endtask

    task automatic test_reset();
        axi_aresetn = 1'b0;
        repeat (3) @(negedge axi_aclk);
        checks++;
        if ({axi_awready, axi_wready, axi_bvalid, axi_bid, axi_bresp, mem_we, mem_addr,
             mem_wdata, mem_wstrb, err_wlast, outstanding} !== 119'd0) begin
            errors++;
            $display("FAIL reset_outputs awready=%b wready=%b bvalid=%b mem_we=%b outstanding=%0d required all 0",
                     axi_awready, axi_wready, axi_bvalid, mem_we, outstanding);
        end
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        checks++;
        if (axi_awready !== 1'b1) begin
            errors++; $display("FAIL reset_release_awready got=%b required 1", axi_awready);
        end
    endtask

    task automatic test_incr();
        send_aw(4'd3, 32'h100, 8'd3, 3'd3, 2'b01);
        checks++;
        if (axi_wready !== 1'b0) begin
            errors++; $display("FAIL incr_latency_n1 wready=%b required 0", axi_wready);
        end
        @(negedge axi_aclk);
        checks++;
        if (axi_wready !== 1'b1) begin
            errors++; $display("FAIL incr_latency_n2 wready=%b required 1", axi_wready);
        end
        for (int i = 0; i < 4; i++) begin
            send_w(64'hA5A5_0000_0000_0000 + 64'(i), 8'h0F << i, i == 3);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h100 + 32'(i * 8) ||
                mem_wdata !== 64'hA5A5_0000_0000_0000 + 64'(i) || mem_wstrb !== (8'h0F << i)) begin
                errors++;
                $display("FAIL incr_beat%0d we=%b addr=%h data=%h strb=%h required we=1 addr=%h",
                         i, mem_we, mem_addr, mem_wdata, mem_wstrb, 32'h100 + 32'(i * 8));
            end
        end
        checks++;
        if (axi_bvalid !== 1'b1 || axi_bid !== 4'd3 || axi_bresp !== 2'b00) begin
            errors++;
            $display("FAIL incr_bresp bvalid=%b bid=%0d bresp=%b required 1/3/00", axi_bvalid, axi_bid, axi_bresp);
        end
        pop_b();
        checks++;
        if (axi_bvalid !== 1'b0) begin
            errors++; $display("FAIL incr_bpop bvalid=%b required 0", axi_bvalid);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h38, 32'h20, 32'h28, 32'h30};
        send_aw(4'd1, 32'h38, 8'd3, 3'd3, 2'b10);
        for (int i = 0; i < 4; i++) begin
            send_w(64'h1111 * 64'(i + 1), 8'hFF, i == 3);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== exp_addr[i]) begin
                errors++;
                $display("FAIL wrap_beat%0d we=%b addr=%h required we=1 addr=%h", i, mem_we, mem_addr, exp_addr[i]);
            end
        end
        checks++;
        if (axi_bvalid !== 1'b1 || axi_bid !== 4'd1 || axi_bresp !== 2'b00) begin
            errors++;
            $display("FAIL wrap_bresp bvalid=%b bid=%0d bresp=%b required 1/1/00", axi_bvalid, axi_bid, axi_bresp);
        end
        pop_b();
    endtask

    task automatic test_illegal();
        logic [1:0]  burst [4];
        logic [31:0] addr [4];
        logic [7:0]  len [4];
        logic [2:0]  size [4];
        logic        exp_we [4];
        logic [1:0]  exp_resp [4];
        burst = '{2'b11, 2'b01, 2'b01, 2'b01};
        addr  = '{32'h400, 32'hFF8, 32'h500, 32'hFF0};
        len   = '{8'd0, 8'd1, 8'd0, 8'd1};
        size  = '{3'd3, 3'd3, 3'd4, 3'd3};
        exp_we   = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_resp = '{2'b10, 2'b10, 2'b10, 2'b00};
        for (int v = 0; v < 4; v++) begin
            send_aw(4'(v + 4), addr[v], len[v], size[v], burst[v]);
            for (int j = 0; j <= int'(len[v]); j++) begin
                send_w(64'hDEAD_BEEF, 8'hFF, j == int'(len[v]));
                checks++;
                if (mem_we !== exp_we[v]) begin
                    errors++; $display("FAIL illegal_v%0d_beat%0d mem_we=%b required %b", v, j, mem_we, exp_we[v]);
                end
            end
            checks++;
            if (axi_bvalid !== 1'b1 || axi_bid !== 4'(v + 4) || axi_bresp !== exp_resp[v]) begin
                errors++;
                $display("FAIL illegal_v%0d_bresp bvalid=%b bid=%0d bresp=%b required 1/%0d/%b",
                         v, axi_bvalid, axi_bid, axi_bresp, v + 4, exp_resp[v]);
            end
            pop_b();
        end
    endtask

    task automatic test_wlast_err();
        send_aw(4'd6, 32'h200, 8'd1, 3'd3, 2'b01);
        send_w(64'h77, 8'hFF, 1'b1);
        checks++;
        if (err_wlast !== 1'b1 || mem_we !== 1'b1 || axi_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wlast_early err=%b we=%b bvalid=%b required 1/1/0", err_wlast, mem_we, axi_bvalid);
        end
        send_w(64'h78, 8'hFF, 1'b1);
        checks++;
        if (err_wlast !== 1'b0 || axi_bvalid !== 1'b1 || axi_bid !== 4'd6 || axi_bresp !== 2'b10 ||
            axi_wready !== 1'b0 || mem_addr !== 32'h208) begin
            errors++;
            $display("FAIL wlast_end err=%b bvalid=%b bid=%0d bresp=%b wready=%b addr=%h required 0/1/6/10/0/208",
                     err_wlast, axi_bvalid, axi_bid, axi_bresp, axi_wready, mem_addr);
        end
        pop_b();
    endtask

    task automatic test_outstanding();
        for (int i = 0; i < 5; i++) send_aw(4'(i), 32'h2000 + 32'(i * 8), 8'd0, 3'd3, 2'b01);
        checks++;
        if (axi_awready !== 1'b0 || outstanding !== 3'd4) begin
            errors++;
            $display("FAIL outst_full awready=%b outstanding=%0d required 0/4", axi_awready, outstanding);
        end
        axi_awid = 4'd15; axi_awvalid = 1'b1;
        repeat (3) @(negedge axi_aclk);
        axi_awvalid = 1'b0;
        checks++;
        if (outstanding !== 3'd4) begin
            errors++; $display("FAIL outst_nobypass outstanding=%0d required 4", outstanding);
        end
        for (int i = 0; i < 5; i++) begin
            send_w(64'(i), 8'hFF, 1'b1);
            checks++;
            if (axi_bvalid !== 1'b1 || axi_bid !== 4'(i) || axi_bresp !== 2'b00) begin
                errors++;
                $display("FAIL outst_b%0d bvalid=%b bid=%0d bresp=%b required 1/%0d/00", i, axi_bvalid, axi_bid, axi_bresp, i);
            end
            pop_b();
        end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 5; i++) send_aw(4'(i + 8), 32'h3000 + 32'(i * 8), 8'd0, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) send_w(64'(i), 8'hFF, 1'b1);
        axi_wvalid = 1'b1; axi_wlast = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge axi_aclk);
            checks++;
            if (axi_wready !== 1'b0 || axi_bvalid !== 1'b1 || axi_bid !== 4'd8) begin
                errors++;
                $display("FAIL bp_hold%0d wready=%b bvalid=%b bid=%0d required 0/1/8", k, axi_wready, axi_bvalid, axi_bid);
            end
        end
        axi_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (axi_bvalid !== 1'b1 || axi_bid !== 4'(i + 8)) begin
                errors++; $display("FAIL bp_drain%0d bvalid=%b bid=%0d required 1/%0d", i, axi_bvalid, axi_bid, i + 8);
            end
            pop_b();
        end
        send_w(64'h5, 8'hFF, 1'b1);
        checks++;
        if (axi_bvalid !== 1'b1 || axi_bid !== 4'd12) begin
            errors++; $display("FAIL bp_last bvalid=%b bid=%0d required 1/12", axi_bvalid, axi_bid);
        end
        pop_b();
    endtask

    task automatic test_reset_mid();
        send_aw(4'd7, 32'h300, 8'd3, 3'd3, 2'b01);
        send_w(64'h1, 8'hFF, 1'b0);
        send_w(64'h2, 8'hFF, 1'b0);
        axi_aresetn = 1'b0;
        @(negedge axi_aclk);
        checks++;
        if ({axi_awready, axi_wready, axi_bvalid, axi_bid, axi_bresp, mem_we, mem_addr,
             mem_wdata, mem_wstrb, err_wlast, outstanding} !== 119'd0) begin
            errors++;
            $display("FAIL midrst_outputs awready=%b wready=%b bvalid=%b mem_we=%b addr=%h required all 0",
                     axi_awready, axi_wready, axi_bvalid, mem_we, mem_addr);
        end
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        checks++;
        if (axi_awready !== 1'b1) begin
            errors++; $display("FAIL midrst_awready got=%b required 1", axi_awready);
        end
        repeat (4) @(negedge axi_aclk);
        checks++;
        if (axi_bvalid !== 1'b0 || axi_wready !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet bvalid=%b wready=%b required 0/0", axi_bvalid, axi_wready);
        end
        send_aw(4'd2, 32'h40, 8'd0, 3'd3, 2'b00);
        send_w(64'h99, 8'h3C, 1'b1);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h40 || axi_bvalid !== 1'b1 || axi_bid !== 4'd2 || axi_bresp !== 2'b00) begin
            errors++;
            $display("FAIL midrst_recover we=%b addr=%h bvalid=%b bid=%0d bresp=%b required 1/40/1/2/00",
                     mem_we, mem_addr, axi_bvalid, axi_bid, axi_bresp);
        end
        pop_b();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_illegal();
        test_wlast_err();
        test_outstanding();
        test_back_pressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_wr_burst_slave.md
AXI_WR_BURST_SLAVE -- requirements
Module: axi_wr_burst_slave

Interface
REQ-001 SHALL have parameter IDW, default 4, write ID width.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 64, data width; legal values 32/64/128.
REQ-004 SHALL have parameter OUTSTANDING, default 4, AW-queue and B-queue depth; power of two, at least 2.
REQ-005 SHALL have one clock, axi_aclk; reset axi_aresetn is synchronous and active-low.
REQ-006 axi_aclk  in  1  clock; all state updates on the rising edge.
REQ-007 axi_aresetn  in  1  synchronous active-low reset.
REQ-008 axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  IDW/AW/8/3/2/1  write address channel.
REQ-009 axi_awready  out  1  AW queue can accept.
REQ-010 axi_wdata/wstrb/wlast/wvalid  in  DW/DW/8/1/1  write data channel.
REQ-011 axi_wready  out  1  beat accepted this cycle.
REQ-012 axi_bid/bresp/bvalid  out  IDW/2/1  write response; axi_bready  in  1.
REQ-013 mem_we/mem_addr/mem_wdata/mem_wstrb  out  1/AW/DW/DW/8  registered backend write port.
REQ-014 err_wlast  out  1  one-cycle pulse on a WLAST mismatch; outstanding  out  $clog2(OUTSTANDING)+1  AW entries queued.

Function
REQ-015 AW handshake when awvalid && awready; awready SHALL equal not(AW queue full), with no bypass when full.
REQ-016 Each accepted AW SHALL be queued with id, addr, len, size, burst and an illegal flag.
REQ-017 Illegal means any of: burst==2'b11; WRAP with len not in {1,3,7,15}; 2^size > DW/8; or a 4KB-boundary crossing by INCR.
REQ-018 W FSM SHALL have states W_IDLE and W_DATA.
REQ-019 In W_IDLE with the AW queue non-empty, the FSM SHALL pop the head into working registers and go to W_DATA.
REQ-020 In W_DATA, wready SHALL be 1 only while the B queue is not full; wready SHALL be 0 in W_IDLE.
REQ-021 Latency: an AW handshake in cycle N into an empty queue SHALL give wready=1 in cycle N+2.
REQ-022 The beat counter SHALL start at 0, increment per W handshake, and mark the last beat when counter==len.
REQ-023 A W handshake with wlast != (last beat) SHALL set the burst response to SLVERR and pulse err_wlast the next cycle.
REQ-024 After a mismatch, the burst SHALL still end on beat len+1; early or extra wlast does not change the beat count.
REQ-025 Each non-illegal beat SHALL drive mem_we=1 in the next cycle, with mem_addr, mem_wdata and mem_wstrb of that beat.
REQ-026 Beats of an illegal burst SHALL be consumed with mem_we=0 and response SLVERR.
REQ-027 Address update SHALL be: FIXED unchanged; INCR +2^size; WRAP +2^size, wrapped within the boundary (len+1)*2^size aligned to that size.
REQ-028 On the last-beat handshake, {id, resp} SHALL be pushed to the B queue, and the FSM goes to W_IDLE.
REQ-029 A pop from the same cycle SHALL not bypass W_IDLE (one idle cycle between bursts).
REQ-030 resp SHALL be OKAY=2'b00 or SLVERR=2'b10; EXOKAY and DECERR are never produced.
REQ-031 bvalid SHALL equal B queue non-empty, giving a response the cycle after the last beat, in AW order.
REQ-032 bid and bresp SHALL hold stable until a bready handshake.
REQ-033 A simultaneous B queue push and pop SHALL leave the count unchanged; push when full cannot occur (REQ-020).
REQ-034 W beats arriving before any AW SHALL stall (wready=0), never dropped.
REQ-035 outstanding SHALL be the AW queue occupancy and SHALL exclude the burst held in working registers.

Reset
REQ-036 While axi_aresetn=0 and on the following edge, all outputs SHALL be 0.
REQ-037 Reset SHALL empty both queues, clear the counter and working registers, and put the FSM in W_IDLE.
REQ-038 A reset mid-burst SHALL discard the burst with no B response.
REQ-039 awready SHALL be 1 in the first cycle after reset release.

Structure
REQ-040 Package axi_pkg SHALL hold the burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/SLVERR), the W FSM state enum, and the 4KB constant.
REQ-041 Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count) SHALL be instantiated twice, for the AW and B queues.

Verification
REQ-042 AW id=3 addr=0x100 len=3 size=3 INCR, 4 beats with wlast on beat 4 -> mem_addr 0x100/0x108/0x110/0x118, bid=3, bresp=OKAY one cycle after beat 4.
REQ-043 WRAP addr=0x38 len=3 size=3 -> mem_addr 0x38, 0x20, 0x28, 0x30.
REQ-044 5 AW with no W traffic, OUTSTANDING=4 -> awready=0 after 5 accepted (4 queued plus 1 in working registers).
REQ-045 Same run: outstanding=4, then all 5 B responses return in order.
REQ-046 len=1 burst with wlast on beat 1 -> err_wlast pulse, 2 beats consumed, bresp=SLVERR.
REQ-047 awburst=2'b11 len=0 -> mem_we stays 0, bresp=SLVERR.
REQ-048 bready=0 for 4 completed bursts -> wready=0; holding bid stable 10 cycles, then bready=1 drains in order.
REQ-049 Reset asserted mid-burst -> next cycle all outputs 0; no bvalid for the aborted burst; awready=1 after release.
